bin_to_bcd_seq: RTL and testbench

Sequential binary-to-BCD converter that produces the packed 4-digit hex-nibble word driven into the seven-segment display's `i_Digit` input. The upstream counter/controller places a binary value on `i_bin` and pulses `i_start`. The block runs shift-and-add-3 (double-dabble), one input bit per clock. It holds the packed BCD result stable until the next conversion completes, so the display scan never sees intermediate values. Values that are out of range display as all-`E`.

---
 rtl/bin_to_bcd_seq_pkg.sv | 20 ++
 rtl/bin_to_bcd_seq_digit_adjust.sv | 10 +
 rtl/bin_to_bcd_seq.sv | 106 ++++++++++
 tb/tb_bin_to_bcd_seq.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter feeding the
// seven-segment display digit word.
package bin_to_bcd_seq_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } bcdState_e;

  localparam logic [3:0] BCD_ERR_NIBBLE = 4'hE;

  // Largest value representable in the given number of decimal digits.
  function automatic int bcd_max(input int digits);
    int acc;
    acc = 1;
    for (int i = 0; i < digits; i++) acc = acc * 10;
    return acc - 1;
  endfunction

endpackage

// File: rtl/bin_to_bcd_seq_digit_adjust.sv
// Double-dabble digit correction: a nibble of 5 or more gets +3 before the
// next left shift so that it carries correctly into the next decimal digit.
module bcd_digit_adjust (
  input  logic [3:0] nibIn,
  output logic [3:0] nibOut
);

  assign nibOut = (nibIn >= 4'd5) ? nibIn + 4'd3 : nibIn;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-and-add-3 converter, one input bit per clock; the packed
// BCD output only changes on completion so the display never sees partials.
module bin_to_bcd_seq
  import bin_to_bcd_seq_pkg::*;
#(
  parameter int IN_WIDTH = 14,
  parameter int DIGITS   = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [IN_WIDTH-1:0]   i_bin,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [4*DIGITS-1:0]   o_bcd,
  output logic                  o_overflow
);

  localparam int          CNT_W   = $clog2(IN_WIDTH + 1);
  localparam int          BCD_W   = 4 * DIGITS;
  localparam logic [31:0] BIN_MAX = 32'(bcd_max(DIGITS));

  bcdState_e           state, stateNext;
  logic [CNT_W-1:0]    bitCnt;
  logic [IN_WIDTH-1:0] shiftReg;
  logic [BCD_W-1:0]    scratch;
  logic [BCD_W-1:0]    adjusted;
  logic [BCD_W-1:0]    shifted;
  logic                ovfPend;
  logic                ovfNow;
  logic                accept;
  logic                finish;

  // Overflowing results are replaced by an all-E word on the display.
  function automatic logic [BCD_W-1:0] satBcd(input logic ovf,
                                              input logic [BCD_W-1:0] bcd);
    return ovf ? {DIGITS{BCD_ERR_NIBBLE}} : bcd;
  endfunction

  for (genvar d = 0; d < DIGITS; d++) begin : gAdj
    bcd_digit_adjust uAdj (
      .nibIn  (scratch[4*d +: 4]),
      .nibOut (adjusted[4*d +: 4])
    );
  end

  assign shifted = {adjusted[BCD_W-2:0], shiftReg[IN_WIDTH-1]};
  assign ovfNow  = ({{(32-IN_WIDTH){1'b0}}, i_bin} > BIN_MAX);
  assign o_busy  = (state == ST_SHIFT);

  always_comb begin
    stateNext = state;
    accept    = 1'b0;
    finish    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_start) begin
          accept    = 1'b1;
          stateNext = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (bitCnt == CNT_W'(1)) begin
          finish    = 1'b1;
          stateNext = ST_IDLE;
        end
      end
    endcase
  end

  // Control and visible result: reset aborts any conversion in flight.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= ST_IDLE;
      bitCnt     <= '0;
      o_done     <= 1'b0;
      o_bcd      <= '0;
      o_overflow <= 1'b0;
    end else begin
      state  <= stateNext;
      o_done <= finish;
      if (accept) begin
        bitCnt <= CNT_W'(IN_WIDTH);
      end else if (state == ST_SHIFT) begin
        bitCnt <= bitCnt - CNT_W'(1);
      end
      if (finish) begin
        o_bcd      <= satBcd(ovfPend, shifted);
        o_overflow <= ovfPend;
      end
    end
  end

  // Working registers are fully reloaded on every accepted request.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      shiftReg <= i_bin;
      scratch  <= '0;
      ovfPend  <= ovfNow;
    end else if (state == ST_SHIFT) begin
      shiftReg <= shiftReg << 1;
      scratch  <= shifted;
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq: stimulus queues expected results, a
// monitor checks every o_done pulse against the queue head.
module tb_bin_to_bcd_seq;

  localparam int IN_WIDTH = 14;
  localparam int DIGITS   = 4;
  localparam int LAT      = IN_WIDTH;

  typedef struct {
    logic [15:0] bcd;
    logic        ovf;
    int          cyc;
  } exp_t;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_start = 1'b0;
  logic [13:0]   i_bin = '0;
  logic          o_busy;
  logic          o_done;
  logic [15:0]   o_bcd;
  logic          o_overflow;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t q[$];

  bin_to_bcd_seq #(.IN_WIDTH(IN_WIDTH), .DIGITS(DIGITS)) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_start    (i_start),
    .i_bin      (i_bin),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_bcd      (o_bcd),
    .o_overflow (o_overflow)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every completion must match the oldest outstanding expectation.
  always @(negedge i_clk) begin
    if (!i_rst && o_done) begin
      exp_t e;
      check("done_not_busy", {31'd0, o_busy}, 32'd0);
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got o_done=1 bcd=%0h expected no completion (cycle %0d)", o_bcd, cyc);
      end else begin
        e = q.pop_front();
        check("bcd", {16'd0, o_bcd}, {16'd0, e.bcd});
        check("overflow", {31'd0, o_overflow}, {31'd0, e.ovf});
        check("latency", cyc, e.cyc);
      end
    end
  end

  // Pulse start for one cycle; returns with time just after the accepting edge.
  task automatic issue(input logic [13:0] bin);
    i_bin   = bin;
    i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
  endtask

  task automatic expect_res(input logic [15:0] bcd, input logic ovf, input int doneCyc);
    exp_t e;
    e.bcd = bcd; e.ovf = ovf; e.cyc = doneCyc;
    q.push_back(e);
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while (q.size() != 0 && n < budget) begin
      @(posedge i_clk);
      n++;
    end
    @(negedge i_clk); @(negedge i_clk);
    check(name, q.size(), 0);
  endtask

  initial begin
    int busyCnt;
    // Reset state
    repeat (3) @(posedge i_clk);
    #1 i_rst = 1'b0;
    check("rst_busy", {31'd0, o_busy}, 0);
    check("rst_done", {31'd0, o_done}, 0);
    check("rst_bcd", {16'd0, o_bcd}, 0);
    check("rst_ovf", {31'd0, o_overflow}, 0);

    // Zero, with busy-width measurement
    issue(14'd0);
    expect_res(16'h0000, 1'b0, cyc + LAT);
    busyCnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge i_clk);
      if (o_busy) busyCnt++;
    end
    check("busy_cycles", busyCnt, 14);
    drain("drain_zero", 40);

    @(posedge i_clk); #1;
    issue(14'd1234); expect_res(16'h1234, 1'b0, cyc + LAT); drain("drain_1234", 40);
    issue(14'd9999); expect_res(16'h9999, 1'b0, cyc + LAT); drain("drain_9999", 40);
    @(posedge i_clk); #1;
    issue(14'd10000); expect_res(16'hEEEE, 1'b1, cyc + LAT); drain("drain_10000", 40);
    @(posedge i_clk); #1;
    issue(14'd16383); expect_res(16'hEEEE, 1'b1, cyc + LAT); drain("drain_16383", 40);
    @(posedge i_clk); #1;
    issue(14'd42); expect_res(16'h0042, 1'b0, cyc + LAT); drain("drain_42", 40);
    @(posedge i_clk); #1;

    // Sustained start: next request is taken in the o_done cycle
    i_bin = 14'd5; i_start = 1'b1;
    @(posedge i_clk); #1;
    expect_res(16'h0005, 1'b0, cyc + LAT);
    i_bin = 14'd6;
    repeat (LAT + 1) @(posedge i_clk); #1;
    expect_res(16'h0006, 1'b0, cyc + LAT);
    i_bin = 14'd7;
    repeat (LAT + 1) @(posedge i_clk); #1;
    expect_res(16'h0007, 1'b0, cyc + LAT);
    i_start = 1'b0;
    i_bin = 14'd99;
    drain("drain_b2b", 80);
    @(posedge i_clk); #1;

    // Mid-SHIFT start pulse and input change are ignored
    issue(14'd1234);
    expect_res(16'h1234, 1'b0, cyc + LAT);
    repeat (5) @(posedge i_clk); #1;
    i_bin = 14'd777; i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    drain("drain_midstart", 40);
    repeat (20) @(posedge i_clk); #1;

    // Reset in the 7th SHIFT cycle aborts; start during reset is ignored
    issue(14'd1234);
    repeat (6) @(posedge i_clk); #1;
    i_rst = 1'b1; i_start = 1'b1; i_bin = 14'd5;
    @(posedge i_clk); #1;
    i_rst = 1'b0; i_start = 1'b0;
    check("abort_bcd", {16'd0, o_bcd}, 0);
    check("abort_busy", {31'd0, o_busy}, 0);
    check("abort_done", {31'd0, o_done}, 0);
    @(posedge i_clk); #1;
    check("abort_start_ignored", {31'd0, o_busy}, 0);
    repeat (30) @(posedge i_clk);
    @(negedge i_clk);
    check("abort_no_pending", q.size(), 0);
    check("abort_bcd_held", {16'd0, o_bcd}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
